led_pattern_ctrl: RTL and testbench

LED_PATTERN_CTRL -- requirements
Module: led_pattern_ctrl

---
 rtl/led_pattern_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// rtl/led_pattern_ctrl.sv - command-driven LED pattern sequencer (shift left/right, bounce)
//
// Purpose:
//   Accepts pattern commands over a valid/ready handshake and steps a one-hot
//   LED pattern at a programmable rate. The base step period is TIME_count
//   clock cycles, divided by 2^speed and never shorter than one cycle.
//
// Parameters:
//   LED_quantity   - number of LEDs driven (minimum 2)
//   TIME_count     - base step period in clk cycles at speed 0
//   TIME_count_bit - bit width needed to hold TIME_count
//
// Ports:
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   cmd_valid  in   a command is offered
//   cmd_ready  out  a command can be accepted this cycle (low only in LOAD)
//   cmd_mode   in   0 OFF, 1 SHIFT_L, 2 SHIFT_R, 3 BOUNCE
//   cmd_speed  in   speed select s, step period = max(TIME_count >> s, 1)
//   pause      in   level-sensitive freeze request
//   LED        out  registered LED pattern
//   step       out  registered one-cycle pulse on each pattern advance
//   busy       out  high in LOAD, RUN and PAUSE

module led_pattern_ctrl #(
    parameter int LED_quantity   = 8,
    parameter int TIME_count     = 100000000,
    parameter int TIME_count_bit = 27
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_mode,
    input  logic [2:0]              cmd_speed,
    input  logic                    pause,
    output logic [LED_quantity-1:0] LED,
    output logic                    step,
    output logic                    busy
);

    // One spare bit on the counter so period-1 comparisons never overflow.
    localparam int CW = TIME_count_bit + 1;
    localparam int N  = LED_quantity;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_PAUSE = 2'd3;

    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_SHIFT_L = 2'd1;
    localparam logic [1:0] MODE_SHIFT_R = 2'd2;
    localparam logic [1:0] MODE_BOUNCE  = 2'd3;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam logic [CW-1:0] BASE_PERIOD = CW'(TIME_count);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [N-1:0]  LED_FIRST   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0]  LED_LAST    = {1'b1, {(N-1){1'b0}}};

    logic [1:0]    state;
    logic [1:0]    mode_q;
    logic [2:0]    speed_q;
    logic          dir;
    logic [CW-1:0] cnt;

    logic          accept;
    logic [CW-1:0] shifted_period;
    logic [CW-1:0] period;
    logic          wrap;
    logic          led_onehot;

    logic [N-1:0]  load_led;
    logic          load_dir;
    logic [N-1:0]  adv_led;
    logic          adv_dir;
    logic          eff_left;
    logic [N-1:0]  bounce_nxt;

    assign cmd_ready = (state != ST_LOAD);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // High speed selects can shift the period down to zero; clamp to one
    // so the pattern then advances on every cycle.
    assign shifted_period = BASE_PERIOD >> speed_q;
    assign period         = (shifted_period == '0) ? CNT_ONE : shifted_period;
    assign wrap           = (cnt == (period - CNT_ONE));

    assign led_onehot = (LED != '0) && ((LED & (LED - LED_FIRST)) == '0);

    // Initial pattern and direction for the latched mode.
    always_comb begin
        load_led = '0;
        load_dir = DIR_LEFT;
        case (mode_q)
            MODE_SHIFT_L: begin
                load_led = LED_FIRST;
                load_dir = DIR_LEFT;
            end
            MODE_SHIFT_R: begin
                load_led = LED_LAST;
                load_dir = DIR_RIGHT;
            end
            MODE_BOUNCE: begin
                load_led = LED_FIRST;
                load_dir = DIR_LEFT;
            end
            default: begin
                load_led = '0;
                load_dir = DIR_LEFT;
            end
        endcase
    end

    // Next pattern for one advance. A pattern that is not one-hot is
    // replaced by the mode's initial value instead of being propagated.
    always_comb begin
        adv_led    = LED;
        adv_dir    = dir;
        eff_left   = 1'b0;
        bounce_nxt = '0;
        case (mode_q)
            MODE_SHIFT_L: begin
                if (led_onehot) begin
                    adv_led = {LED[N-2:0], LED[N-1]};
                end else begin
                    adv_led = LED_FIRST;
                    adv_dir = DIR_LEFT;
                end
            end
            MODE_SHIFT_R: begin
                if (led_onehot) begin
                    adv_led = {LED[0], LED[N-1:1]};
                end else begin
                    adv_led = LED_LAST;
                    adv_dir = DIR_RIGHT;
                end
            end
            MODE_BOUNCE: begin
                if (led_onehot) begin
                    // Direction normally flips when an end is reached; the end
                    // checks here also keep a stale direction from shifting the
                    // bit off the edge.
                    eff_left   = (dir == DIR_LEFT) ? !LED[N-1] : LED[0];
                    bounce_nxt = eff_left ? (LED << 1) : (LED >> 1);
                    adv_led    = bounce_nxt;
                    if (bounce_nxt[N-1]) begin
                        adv_dir = DIR_RIGHT;
                    end else if (bounce_nxt[0]) begin
                        adv_dir = DIR_LEFT;
                    end else begin
                        adv_dir = eff_left ? DIR_LEFT : DIR_RIGHT;
                    end
                end else begin
                    adv_led = LED_FIRST;
                    adv_dir = DIR_LEFT;
                end
            end
            default: begin
                adv_led = LED;
                adv_dir = dir;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mode_q  <= MODE_OFF;
            speed_q <= 3'd0;
            dir     <= DIR_LEFT;
            cnt     <= '0;
            LED     <= '0;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;
            if (accept) begin
                // A new command beats a pending wrap and the pause input.
                mode_q  <= cmd_mode;
                speed_q <= cmd_speed;
                state   <= ST_LOAD;
            end else begin
                case (state)
                    ST_IDLE: begin
                        cnt <= '0;
                    end
                    ST_LOAD: begin
                        LED <= load_led;
                        dir <= load_dir;
                        cnt <= '0;
                        if (mode_q == MODE_OFF) begin
                            state <= ST_IDLE;
                        end else if (pause) begin
                            state <= ST_PAUSE;
                        end else begin
                            state <= ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (wrap) begin
                            cnt  <= '0;
                            LED  <= adv_led;
                            dir  <= adv_dir;
                            step <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                        if (pause) begin
                            state <= ST_PAUSE;
                        end
                    end
                    ST_PAUSE: begin
                        // Counter and pattern hold; counting resumes from here.
                        if (!pause) begin
                            state <= ST_RUN;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb/tb_led_pattern_ctrl.sv - directed scoreboard bench for led_pattern_ctrl

module tb_led_pattern_ctrl;

    localparam int N   = 8;
    localparam int TC  = 4;
    localparam int TCB = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_mode;
    logic [2:0]   cmd_speed;
    logic         pause;
    logic [N-1:0] LED;
    logic         step;
    logic         busy;

    int errors = 0;
    int checks = 0;
    int exp_q[$];

    led_pattern_ctrl #(
        .LED_quantity   (N),
        .TIME_count     (TC),
        .TIME_count_bit (TCB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_speed (cmd_speed),
        .pause     (pause),
        .LED       (LED),
        .step      (step),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_step(input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (step === 1'b1) begin
                cyc = i;
                break;
            end
        end
    endtask

    // Offer one command for a single edge, then let LOAD complete.
    task automatic issue(input logic [1:0] m, input logic [2:0] s);
        cmd_mode  = m;
        cmd_speed = s;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
    endtask

    // Pop each expected pattern as the DUT produces the matching step pulse.
    task automatic run_scoreboard(input string tag, input int gap);
        int cyc;
        int e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_step(gap + 4, cyc);
            chk({tag, "_gap"}, cyc, gap);
            chk({tag, "_led"}, LED, e);
            if (cyc < 0) exp_q.delete();
        end
    endtask

    initial begin
        int steps_seen;
        int led_changes;

        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 2'd1;
        cmd_speed = 3'd0;
        pause     = 1'b0;
        tick();
        tick();
        chk("rst_led", LED, 0);
        chk("rst_step", step, 0);
        chk("rst_busy", busy, 0);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_ready", cmd_ready, 1);
        tick();
        chk("idle_busy", busy, 0);

        // SHIFT_L, speed 0: one-cycle LOAD latency, then a step every 4 cycles.
        cmd_mode  = 2'd1;
        cmd_speed = 3'd0;
        cmd_valid = 1'b1;
        tick();
        chk("load_ready", cmd_ready, 0);
        chk("load_busy", busy, 1);
        chk("load_led_pending", LED, 0);
        cmd_valid = 1'b0;
        tick();
        chk("shl_init", LED, 8'h01);
        for (int i = 1; i < N; i++) exp_q.push_back(1 << i);
        exp_q.push_back(8'h01);
        run_scoreboard("shl", 4);

        // BOUNCE, speed 1: period 2, both ends visited once per turn.
        issue(2'd3, 3'd1);
        chk("bnc_init", LED, 8'h01);
        chk("bnc_init_step", step, 0);
        for (int i = 1; i < N; i++) exp_q.push_back(1 << i);
        for (int i = N - 2; i >= 0; i--) exp_q.push_back(1 << i);
        exp_q.push_back(8'h02);
        run_scoreboard("bnc", 2);

        // SHIFT_R with pause held 10 cycles after two counted cycles.
        issue(2'd2, 3'd0);
        chk("shr_init", LED, 8'h80);
        tick();
        tick();
        chk("shr_prepause_step", step, 0);
        pause = 1'b1;
        tick();
        steps_seen  = 0;
        led_changes = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (step === 1'b1) steps_seen++;
            if (LED !== 8'h80) led_changes++;
        end
        chk("pause_steps", steps_seen, 0);
        chk("pause_led_changes", led_changes, 0);
        chk("pause_busy", busy, 1);
        chk("pause_ready", cmd_ready, 1);
        pause = 1'b0;
        exp_q.push_back(8'h40);
        run_scoreboard("pause_resume", 2);
        exp_q.push_back(8'h20);
        run_scoreboard("shr", 4);

        // Command offered on the exact wrap edge wins over the advance.
        tick();
        tick();
        tick();
        cmd_mode  = 2'd1;
        cmd_speed = 3'd0;
        cmd_valid = 1'b1;
        tick();
        chk("wrapcmd_step", step, 0);
        chk("wrapcmd_led_hold", LED, 8'h20);
        cmd_valid = 1'b0;
        tick();
        chk("wrapcmd_led", LED, 8'h01);
        exp_q.push_back(8'h02);
        run_scoreboard("shl2", 4);

        // Reset mid-RUN overrides a pending command and pause.
        tick();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_mode  = 2'd3;
        pause     = 1'b1;
        tick();
        chk("midrst_led", LED, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_step", step, 0);
        chk("midrst_ready", cmd_ready, 1);
        rst       = 1'b0;
        cmd_valid = 1'b0;
        pause     = 1'b0;
        tick();
        chk("midrst_noaccept_busy", busy, 0);
        chk("midrst_noaccept_led", LED, 0);

        // OFF while running returns to IDLE with no further steps.
        issue(2'd1, 3'd0);
        chk("preoff_init", LED, 8'h01);
        exp_q.push_back(8'h02);
        run_scoreboard("preoff", 4);
        tick();
        issue(2'd0, 3'd0);
        chk("off_led", LED, 0);
        chk("off_busy", busy, 0);
        chk("off_ready", cmd_ready, 1);
        steps_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step === 1'b1) steps_seen++;
        end
        chk("off_steps", steps_seen, 0);
        chk("off_led_hold", LED, 0);

        // Speed 7 shifts the period to zero; it clamps to a step every cycle.
        issue(2'd1, 3'd7);
        chk("spd7_init", LED, 8'h01);
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h04);
        exp_q.push_back(8'h08);
        run_scoreboard("spd7", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
